// File: rtl/display_pkg.sv
// Shared constants, types and helpers for the multiplexed 7-segment display path.
// Glyphs are active-high {g,f,e,d,c,b,a}. Any panel polarity inversion happens at
// the display top level.
package display_pkg;

   localparam int unsigned NUM_DIGITS = 4;
   localparam int unsigned BCD_W      = 4;
   localparam int unsigned SEG_W      = 7;
   localparam int unsigned IDX_W      = 2;
   localparam int unsigned BUS_W      = NUM_DIGITS * BCD_W;

   localparam logic [SEG_W-1:0] SEG_0    = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1    = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2    = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3    = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4    = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5    = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6    = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7    = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8    = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9    = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_DASH = 7'h40;
   localparam logic [SEG_W-1:0] SEG_OFF  = 7'h00;

   // Registered display pin payload: digit enables plus segment pattern.
   typedef struct packed {
      logic [NUM_DIGITS-1:0] an;
      logic [SEG_W-1:0]      seg;
   } disp_out_t;

   // One-hot active-high enable for a digit index.
   function automatic logic [NUM_DIGITS-1:0] digit_onehot(input logic [IDX_W-1:0] idx);
      return NUM_DIGITS'(1) << idx;
   endfunction

   // Select nibble idx of a packed BCD word. Nibble 0 is the units digit.
   function automatic logic [BCD_W-1:0] get_nibble(input logic [BUS_W-1:0] word,
                                                   input logic [IDX_W-1:0] idx);
      logic [BCD_W-1:0] nib;
      case (idx)
         2'd0:    nib = word[3:0];
         2'd1:    nib = word[7:4];
         2'd2:    nib = word[11:8];
         default: nib = word[15:12];
      endcase
      return nib;
   endfunction

endpackage

// File: rtl/module_seg7_decoder.sv
// BCD nibble to active-high 7-segment glyph. Combinational.
// Ports:
//   nibble  - 4-bit digit value; 10..15 render as a dash
//   blank   - forces all segments off
//   glyph_c - active-high segments {g,f,e,d,c,b,a}
module module_seg7_decoder
   import display_pkg::*;
(
   input  logic [BCD_W-1:0] nibble,
   input  logic             blank,
   output logic [SEG_W-1:0] glyph_c
);

   // Glyph lookup. A blank digit overrides every value.
   always_comb begin
      glyph_c = SEG_DASH;
      if (blank) begin
         glyph_c = SEG_OFF;
      end else begin
         case (nibble)
            4'd0:    glyph_c = SEG_0;
            4'd1:    glyph_c = SEG_1;
            4'd2:    glyph_c = SEG_2;
            4'd3:    glyph_c = SEG_3;
            4'd4:    glyph_c = SEG_4;
            4'd5:    glyph_c = SEG_5;
            4'd6:    glyph_c = SEG_6;
            4'd7:    glyph_c = SEG_7;
            4'd8:    glyph_c = SEG_8;
            4'd9:    glyph_c = SEG_9;
            default: glyph_c = SEG_DASH;
         endcase
      end
   end

endmodule

// File: rtl/module_seg7_scan.sv
// Multiplexed 4-digit 7-segment scanner. It drives one digit per refresh slot. The
// BCD word is captured once per frame, so the display never tears. Leading zeros
// can be blanked, and non-BCD nibbles render as a dash.
// Ports:
//   clk_i - system clock
//   rst_i - synchronous active-high reset
//   bcd_i - packed BCD {thousands, hundreds, tens, units}
//   seg_o - segments {g,f,e,d,c,b,a}; active-low when COMMON_ANODE=1
//   an_o  - digit enables, bit k = digit k; active-low when COMMON_ANODE=1
module module_seg7_scan
   import display_pkg::*;
#(
   parameter int unsigned REFRESH_DIV   = 27000,
   parameter int unsigned COMMON_ANODE  = 1,
   parameter int unsigned BLANK_LEADING = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [BUS_W-1:0]      bcd_i,
   output logic [SEG_W-1:0]      seg_o,
   output logic [NUM_DIGITS-1:0] an_o
);

   localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [SEG_W-1:0]      SEG_IDLE = (COMMON_ANODE != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIGITS-1:0] AN_IDLE  = (COMMON_ANODE != 0) ? '1 : '0;

   logic [CNT_W-1:0]      cnt_q;
   logic [IDX_W-1:0]      idx_q;
   logic [BUS_W-1:0]      frame_q;
   disp_out_t             disp_q;

   logic                  tick_c;
   logic [NUM_DIGITS-1:0] zero_from_c;
   logic                  zero_run_c;
   logic [BCD_W-1:0]      nib_c;
   logic                  blank_c;
   logic [SEG_W-1:0]      glyph_c;
   disp_out_t             disp_c;

   // End of a digit slot.
   assign tick_c = (cnt_q == CNT_LAST);

   // zero_from_c[k] is set when nibbles k..3 of the captured frame are all zero.
   // A non-BCD nibble is nonzero here, so it never hides the digits below it.
   always_comb begin
      zero_from_c = '0;
      zero_run_c  = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         zero_run_c     = zero_run_c & (get_nibble(frame_q, IDX_W'(k)) == '0);
         zero_from_c[k] = zero_run_c;
      end
   end

   // The units digit stays lit, so a zero value still shows a single "0".
   assign nib_c   = get_nibble(frame_q, idx_q);
   assign blank_c = (BLANK_LEADING != 0) && (idx_q != '0) && zero_from_c[idx_q];

   module_seg7_decoder u_decoder (
      .nibble  (nib_c),
      .blank   (blank_c),
      .glyph_c (glyph_c)
   );

   // Next pin value. Enable and segments change on the same edge, so the
   // display has no ghost cycle.
   always_comb begin
      disp_c.an  = digit_onehot(idx_q);
      disp_c.seg = glyph_c;
      if (COMMON_ANODE != 0) begin
         disp_c.an  = ~disp_c.an;
         disp_c.seg = ~disp_c.seg;
      end
   end

   // Prescaler, digit index and frame capture. The capture happens on the last
   // tick of a frame, so a mid-frame change waits for the next frame.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         frame_q <= '0;
      end else begin
         cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
         if (tick_c) begin
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
               frame_q <= bcd_i;
            end
         end
      end
   end

   // Output register. It shows the idx/frame of the previous cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         disp_q.an  <= AN_IDLE;
         disp_q.seg <= SEG_IDLE;
      end else begin
         disp_q <= disp_c;
      end
   end

   assign seg_o = disp_q.seg;
   assign an_o  = disp_q.an;

endmodule

// File: tb/tb_module_seg7_scan.sv
// Directed bench for module_seg7_scan with REFRESH_DIV=4 and COMMON_ANODE=1.
// Instance dut blanks leading zeros and instance dut_nb does not. Outputs are
// sampled on the falling edge.
module tb_module_seg7_scan;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] bcd = 16'h0000;
   logic [6:0]  seg_a;
   logic [3:0]  an_a;
   logic [6:0]  seg_b;
   logic [3:0]  an_b;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   module_seg7_scan #(.REFRESH_DIV(4), .COMMON_ANODE(1), .BLANK_LEADING(1)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bcd_i (bcd),
      .seg_o (seg_a),
      .an_o  (an_a)
   );

   module_seg7_scan #(.REFRESH_DIV(4), .COMMON_ANODE(1), .BLANK_LEADING(0)) dut_nb (
      .clk_i (clk),
      .rst_i (rst),
      .bcd_i (bcd),
      .seg_o (seg_b),
      .an_o  (an_b)
   );

   // Advance n rising edges, then stop on the following falling edge.
   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Hold reset for 3 cycles with the given input word, then release it.
   task automatic restart(input logic [15:0] v);
      rst = 1'b1;
      bcd = v;
      cyc(3);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [3:0] ea;
      logic [6:0] es;
      int slot;
      rst = 1'b1;
      bcd = 16'h0000;
      cyc(3);
      checks += 4;
      if (an_a !== 4'hF)  begin errors++; $display("FAIL reset_an: got %h want %h", an_a, 4'hF); end
      if (seg_a !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want %h", seg_a, 7'h7F); end
      if (an_b !== 4'hF)  begin errors++; $display("FAIL reset_an_nb: got %h want %h", an_b, 4'hF); end
      if (seg_b !== 7'h7F) begin errors++; $display("FAIL reset_seg_nb: got %h want %h", seg_b, 7'h7F); end
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         cyc(1);
         slot = (k - 1) / 4;
         ea = 4'(~(4'b0001 << slot));
         es = (slot == 0) ? 7'h40 : 7'h7F;
         checks += 2;
         if (an_a !== ea)  begin errors++; $display("FAIL post_reset_an c%0d: got %h want %h", k, an_a, ea); end
         if (seg_a !== es) begin errors++; $display("FAIL post_reset_seg c%0d: got %h want %h", k, seg_a, es); end
      end
   endtask

   task automatic test_basic();
      logic [6:0] tab [4];
      logic [3:0] ea;
      int slot;
      tab = '{7'h12, 7'h79, 7'h7F, 7'h7F};
      restart(16'h0015);
      cyc(16);
      for (int k = 17; k <= 32; k++) begin
         cyc(1);
         slot = ((k - 1) / 4) % 4;
         ea = 4'(~(4'b0001 << slot));
         checks += 2;
         if (an_a !== ea)        begin errors++; $display("FAIL basic_an c%0d: got %h want %h", k, an_a, ea); end
         if (seg_a !== tab[slot]) begin errors++; $display("FAIL basic_seg c%0d: got %h want %h", k, seg_a, tab[slot]); end
      end
   endtask

   task automatic test_dash();
      logic [6:0] tab [4];
      logic [3:0] ea;
      int slot;
      tab = '{7'h30, 7'h3F, 7'h7F, 7'h7F};
      restart(16'h00A3);
      cyc(16);
      for (int k = 17; k <= 32; k++) begin
         cyc(1);
         slot = ((k - 1) / 4) % 4;
         ea = 4'(~(4'b0001 << slot));
         checks += 2;
         if (an_a !== ea)        begin errors++; $display("FAIL dash_an c%0d: got %h want %h", k, an_a, ea); end
         if (seg_a !== tab[slot]) begin errors++; $display("FAIL dash_seg c%0d: got %h want %h", k, seg_a, tab[slot]); end
      end
   endtask

   task automatic test_tearing();
      logic [6:0] tab_old [4];
      logic [6:0] tab_new [4];
      logic [6:0] es;
      logic [3:0] ea;
      int slot;
      tab_old = '{7'h12, 7'h79, 7'h7F, 7'h7F};
      tab_new = '{7'h24, 7'h19, 7'h7F, 7'h7F};
      restart(16'h0015);
      cyc(16);
      for (int k = 17; k <= 48; k++) begin
         cyc(1);
         slot = ((k - 1) / 4) % 4;
         ea = 4'(~(4'b0001 << slot));
         es = (k <= 32) ? tab_old[slot] : tab_new[slot];
         checks += 2;
         if (an_a !== ea)  begin errors++; $display("FAIL tear_an c%0d: got %h want %h", k, an_a, ea); end
         if (seg_a !== es) begin errors++; $display("FAIL tear_seg c%0d: got %h want %h", k, seg_a, es); end
         if (k == 21) bcd = 16'h0042;
      end
   endtask

   task automatic test_no_blank();
      logic [6:0] tab_nb [4];
      logic [6:0] tab_bl [4];
      logic [3:0] ea;
      int slot;
      tab_nb = '{7'h78, 7'h40, 7'h40, 7'h40};
      tab_bl = '{7'h78, 7'h7F, 7'h7F, 7'h7F};
      restart(16'h0007);
      cyc(16);
      for (int k = 17; k <= 32; k++) begin
         cyc(1);
         slot = ((k - 1) / 4) % 4;
         ea = 4'(~(4'b0001 << slot));
         checks += 3;
         if (an_b !== ea)           begin errors++; $display("FAIL noblank_an c%0d: got %h want %h", k, an_b, ea); end
         if (seg_b !== tab_nb[slot]) begin errors++; $display("FAIL noblank_seg c%0d: got %h want %h", k, seg_b, tab_nb[slot]); end
         if (seg_a !== tab_bl[slot]) begin errors++; $display("FAIL blank7_seg c%0d: got %h want %h", k, seg_a, tab_bl[slot]); end
      end
   endtask

   task automatic test_mid_reset();
      logic [3:0] ea;
      logic [6:0] es;
      int slot;
      restart(16'h0015);
      cyc(16);
      cyc(9);
      checks += 2;
      if (an_a !== 4'b1011) begin errors++; $display("FAIL midrst_pre_an: got %h want %h", an_a, 4'b1011); end
      if (seg_a !== 7'h7F)  begin errors++; $display("FAIL midrst_pre_seg: got %h want %h", seg_a, 7'h7F); end
      rst = 1'b1;
      cyc(1);
      checks += 2;
      if (an_a !== 4'hF)   begin errors++; $display("FAIL midrst_an: got %h want %h", an_a, 4'hF); end
      if (seg_a !== 7'h7F) begin errors++; $display("FAIL midrst_seg: got %h want %h", seg_a, 7'h7F); end
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         cyc(1);
         slot = (k - 1) / 4;
         ea = 4'(~(4'b0001 << slot));
         es = (slot == 0) ? 7'h40 : 7'h7F;
         checks += 2;
         if (an_a !== ea)  begin errors++; $display("FAIL midrst_scan_an c%0d: got %h want %h", k, an_a, ea); end
         if (seg_a !== es) begin errors++; $display("FAIL midrst_scan_seg c%0d: got %h want %h", k, seg_a, es); end
      end
      cyc(1);
      checks += 2;
      if (an_a !== 4'b1110) begin errors++; $display("FAIL midrst_recap_an: got %h want %h", an_a, 4'b1110); end
      if (seg_a !== 7'h12)  begin errors++; $display("FAIL midrst_recap_seg: got %h want %h", seg_a, 7'h12); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_dash();
      test_tearing();
      test_no_blank();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
